if_fetch_unit: RTL and testbench

//  IF stage of the 5-stage pipeline: owns the PC, issues in-order requests to a

---
 rtl/if_fetch_unit.sv | 114 +++++++++++
 tb/tb_if_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, issues in-order fetches to a variable-latency imem and
// buffers returned words in a small in-order FIFO feeding the IF/ID boundary.
package common;
    localparam logic [1:0] C_PIPE  = 2'd0;
    localparam logic [1:0] C_STALL = 2'd1;
    localparam logic [1:0] C_FLUSH = 2'd2;
    localparam logic [1:0] C_JUMP  = 2'd3;
endpackage

module if_fetch_unit #(
    parameter int unsigned       DWIDTH   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        if_ctrl,
    input  logic [DWIDTH-1:0] jump_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [DWIDTH-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DWIDTH-1:0] imem_rsp_data,
    output logic              if_valid,
    output logic [DWIDTH-1:0] if_pc,
    output logic [DWIDTH-1:0] if_inst
);
    import common::*;

    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam int unsigned   CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DWIDTH-1:0] pc_q;
    logic [DWIDTH-1:0] ent_pc   [DEPTH];
    logic [DWIDTH-1:0] ent_inst [DEPTH];
    logic [DEPTH-1:0]  ent_filled;
    logic [AW-1:0]     head_q, tail_q, fill_q;
    logic [CW-1:0]     count_q, unf_q, drop_q;
    logic [CW:0]       pending_total;

    logic redirect, alloc, pop, fill, drop_rsp, rsp_consumed;

    always_comb begin
        redirect       = (if_ctrl == C_JUMP) || (if_ctrl == C_FLUSH);
        pending_total  = {1'b0, count_q} + {1'b0, drop_q};
        imem_req_valid = rst_n && (count_q < DEPTH_C)
                         && (pending_total <= {1'b0, DEPTH_C}) && !redirect;
        imem_req_addr  = pc_q;

        if_valid = ent_filled[head_q];
        if_pc    = ent_pc[head_q];
        if_inst  = ent_inst[head_q];

        alloc        = imem_req_valid && imem_req_ready;
        pop          = (if_ctrl == C_PIPE) && if_valid;
        drop_rsp     = imem_rsp_valid && (drop_q != '0);
        fill         = imem_rsp_valid && (drop_q == '0) && (unf_q != '0);
        rsp_consumed = imem_rsp_valid && ((drop_q != '0) || (unf_q != '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            unf_q      <= '0;
            drop_q     <= '0;
            ent_filled <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_pc[i]   <= '0;
                ent_inst[i] <= '0;
            end
        end else if (redirect) begin
            // In-flight words become drops; a word landing this very cycle is already accounted for.
            if (if_ctrl == C_JUMP)
                pc_q <= {jump_pc[DWIDTH-1:2], 2'b00};
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            unf_q      <= '0;
            ent_filled <= '0;
            drop_q     <= drop_q + unf_q - CW'(rsp_consumed);
        end else begin
            if (alloc) begin
                ent_pc[tail_q]     <= pc_q;
                ent_filled[tail_q] <= 1'b0;
                tail_q             <= tail_q + AW'(1);
                pc_q               <= pc_q + DWIDTH'(4);
            end
            if (fill) begin
                ent_inst[fill_q]   <= imem_rsp_data;
                ent_filled[fill_q] <= 1'b1;
                fill_q             <= fill_q + AW'(1);
            end
            if (pop) begin
                ent_filled[head_q] <= 1'b0;
                head_q             <= head_q + AW'(1);
            end
            count_q <= count_q + CW'(alloc) - CW'(pop);
            unf_q   <= unf_q + CW'(alloc) - CW'(fill);
            if (drop_rsp)
                drop_q <= drop_q - CW'(1);
        end
    end

    // A response with nothing outstanding is a memory protocol violation.
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_rsp_valid && (drop_q == '0) && (unf_q == '0)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a fixed-latency in-order imem responder.
module tb_if_fetch_unit;
    import common::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  if_ctrl;
    logic [31:0] jump_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    always #5 clk = ~clk;

    if_fetch_unit #(.DWIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_ctrl        (if_ctrl),
        .jump_pc        (jump_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 1;

    logic [31:0] pend_addr[$];
    int          pend_due[$];

    logic        track    = 1'b0;
    logic [31:0] exp_next = '0;

    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_pc, s_inst;

    typedef struct packed {
        logic [1:0]  ctrl;
        logic        rdy;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[19];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit later, record handshakes.
    task automatic cycle(input logic [1:0] ctrl, input logic rdy);
        @(negedge clk);
        rst_n          = 1'b1;
        if_ctrl        = ctrl;
        imem_req_ready = rdy;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        #1;
        s_rv   = imem_req_valid;
        s_addr = imem_req_addr;
        s_iv   = if_valid;
        s_pc   = if_pc;
        s_inst = if_inst;
        if (s_rv && rdy) begin
            pend_addr.push_back(s_addr);
            pend_due.push_back(cyc + lat);
        end
        if (track && s_iv) begin
            chk("stream pc", s_pc, exp_next);
            chk("stream inst", s_inst, inst_of(exp_next));
            if (ctrl == C_PIPE) exp_next += 32'd4;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        if_ctrl        = C_PIPE;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        pend_addr.delete();
        pend_due.delete();
        track = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset req_valid", 32'(imem_req_valid), 32'd0);
        chk("reset if_valid", 32'(if_valid), 32'd0);
        chk("reset if_pc", if_pc, 32'd0);
        chk("reset if_inst", if_inst, 32'd0);
        cyc = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        if_ctrl        = C_PIPE;
        jump_pc        = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        // Latency 1 streaming, then 8 stall cycles filling the FIFO, then drain.
        vecs[0]  = '{C_PIPE,  1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1]  = '{C_PIPE,  1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2]  = '{C_PIPE,  1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3]  = '{C_PIPE,  1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[4]  = '{C_PIPE,  1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[5]  = '{C_STALL, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        vecs[6]  = '{C_STALL, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
        vecs[7]  = '{C_STALL, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[8]  = '{C_STALL, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[9]  = '{C_STALL, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[10] = '{C_STALL, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[11] = '{C_STALL, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[12] = '{C_STALL, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[13] = '{C_PIPE,  1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[14] = '{C_PIPE,  1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
        vecs[15] = '{C_PIPE,  1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
        vecs[16] = '{C_PIPE,  1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
        vecs[17] = '{C_PIPE,  1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
        vecs[18] = '{C_PIPE,  1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};

        lat = 1;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            cycle(vecs[i].ctrl, vecs[i].rdy);
            chk($sformatf("vec%0d req_valid", i), 32'(s_rv), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) chk($sformatf("vec%0d req_addr", i), s_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d if_valid", i), 32'(s_iv), 32'(vecs[i].exp_iv));
            if (vecs[i].exp_iv) begin
                chk($sformatf("vec%0d if_pc", i), s_pc, vecs[i].exp_pc);
                chk($sformatf("vec%0d if_inst", i), s_inst, inst_of(vecs[i].exp_pc));
            end
        end

        // Jump with three words in flight at latency 3; the first lands on the jump cycle.
        lat = 3;
        jump_pc = 32'h103;
        do_reset();
        repeat (3) cycle(C_PIPE, 1'b1);
        cycle(C_JUMP, 1'b1);
        chk("t3 no req on jump", 32'(s_rv), 32'd0);
        track = 1'b1;
        exp_next = 32'h100;
        cycle(C_PIPE, 1'b1);
        chk("t3 redirect req_valid", 32'(s_rv), 32'd1);
        chk("t3 redirect addr", s_addr, 32'h100);
        cycle(C_PIPE, 1'b1);
        cycle(C_PIPE, 1'b1);
        cycle(C_PIPE, 1'b1);
        chk("t3 no stale if_valid", 32'(s_iv), 32'd0);
        cycle(C_PIPE, 1'b1);
        chk("t3 first if_valid", 32'(s_iv), 32'd1);
        chk("t3 first if_pc", s_pc, 32'h100);
        repeat (5) cycle(C_PIPE, 1'b1);
        chk("t3 drained up to", exp_next, 32'h114);

        // Jump coincident with a response at latency 2.
        lat = 2;
        jump_pc = 32'h200;
        do_reset();
        repeat (2) cycle(C_PIPE, 1'b1);
        cycle(C_JUMP, 1'b1);
        chk("t4 no req on jump", 32'(s_rv), 32'd0);
        track = 1'b1;
        exp_next = 32'h200;
        cycle(C_PIPE, 1'b1);
        chk("t4 redirect addr", s_addr, 32'h200);
        cycle(C_PIPE, 1'b1);
        cycle(C_PIPE, 1'b1);
        chk("t4 no stale if_valid", 32'(s_iv), 32'd0);
        cycle(C_PIPE, 1'b1);
        chk("t4 first if_pc", s_pc, 32'h200);
        repeat (3) cycle(C_PIPE, 1'b1);
        chk("t4 drained up to", exp_next, 32'h210);

        // Flush with three in flight and no coincident response; refetch from pc_q.
        lat = 4;
        jump_pc = 32'hFFF0;
        do_reset();
        repeat (3) cycle(C_PIPE, 1'b1);
        cycle(C_FLUSH, 1'b1);
        chk("flush no req", 32'(s_rv), 32'd0);
        track = 1'b1;
        exp_next = 32'h0C;
        cycle(C_PIPE, 1'b1);
        chk("flush refetch req_valid", 32'(s_rv), 32'd1);
        chk("flush refetch addr", s_addr, 32'h0C);
        repeat (3) cycle(C_PIPE, 1'b1);
        cycle(C_PIPE, 1'b1);
        chk("flush no stale if_valid", 32'(s_iv), 32'd0);
        cycle(C_PIPE, 1'b1);
        chk("flush first if_pc", s_pc, 32'h0C);
        repeat (3) cycle(C_PIPE, 1'b1);
        chk("flush drained up to", exp_next, 32'h1C);

        // Back-pressure holds the request stable; reset mid-stream restarts from RESET_PC.
        lat = 1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(C_PIPE, 1'b0);
            chk($sformatf("t5 hold%0d valid", i), 32'(s_rv), 32'd1);
            chk($sformatf("t5 hold%0d addr", i), s_addr, 32'h0);
        end
        cycle(C_PIPE, 1'b1);
        chk("t5 accept addr", s_addr, 32'h0);
        cycle(C_PIPE, 1'b1);
        chk("t5 next addr", s_addr, 32'h4);
        cycle(C_PIPE, 1'b1);
        chk("t5 if_pc before reset", s_pc, 32'h0);
        do_reset();
        cycle(C_PIPE, 1'b1);
        chk("t5 restart addr", s_addr, 32'h0);
        chk("t5 restart if_valid", 32'(s_iv), 32'd0);
        cycle(C_PIPE, 1'b1);
        chk("t5 restart if_valid c1", 32'(s_iv), 32'd0);
        cycle(C_PIPE, 1'b1);
        chk("t5 restart if_valid c2", 32'(s_iv), 32'd1);
        chk("t5 restart if_pc", s_pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
